// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake and halt FSM.
// Optional read-after-write scoreboard is enabled by defining DECODE_HAZARD_EN.
module decode_stage #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned IMM_W      = 6,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [4+2*REG_ADDR_W+IMM_W-1:0]   in_instr,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [3:0]                        out_opcode,
  output logic [REG_ADDR_W-1:0]             out_rd,
  output logic [REG_ADDR_W-1:0]             out_rs1,
  output logic [REG_ADDR_W-1:0]             out_rs2,
  output logic                              out_is_imm,
  output logic [DATA_W-1:0]                 out_imm,
  output logic [2*REG_ADDR_W+IMM_W-1:0]     out_jtarget,
  output logic                              out_writes_rd,
  output logic                              halted,
  input  logic                              resume,
  input  logic                              flush,
  input  logic                              wb_valid,
  input  logic [REG_ADDR_W-1:0]             wb_addr
);

  localparam int unsigned INSTR_W = 4 + 2*REG_ADDR_W + IMM_W;
  localparam int unsigned JT_W    = INSTR_W - 4;
  localparam logic [3:0]  OP_HLT  = 4'hD;

  typedef enum logic {RUN, HALTED} state_e;

  typedef struct packed {
    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  is_imm;
    logic [DATA_W-1:0]     imm;
    logic [JT_W-1:0]       jtarget;
    logic                  writes_rd;
  } dec_t;

  state_e state_q, state_d;
  logic   out_valid_q, out_valid_d;
  dec_t   fields_q, fields_d;
  dec_t   dec;
  logic   stall;
  logic   accept;

  logic [3:0]              opcode;
  logic [REG_ADDR_W-1:0]   f_rd, f_rs1, f_rs2;
  logic [IMM_W-1:0]        f_imm;
  logic signed [IMM_W-1:0] f_imm_s;

  assign opcode  = in_instr[INSTR_W-1 -: 4];
  assign f_rd    = in_instr[INSTR_W-5 -: REG_ADDR_W];
  assign f_rs1   = in_instr[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W];
  assign f_imm   = in_instr[IMM_W-1:0];
  assign f_rs2   = in_instr[IMM_W-1 -: REG_ADDR_W];
  assign f_imm_s = f_imm;

  // Field decode of the incoming word by opcode class
  always_comb begin
    dec         = '0;
    dec.opcode  = opcode;
    dec.jtarget = in_instr[JT_W-1:0];
    case (opcode)
      4'h1, 4'h4, 4'h7: begin
        dec.rd        = f_rd;
        dec.rs1       = f_rs1;
        dec.rs2       = f_rs2;
        dec.writes_rd = 1'b1;
      end
      4'h9, 4'hD: ;
      4'hB, 4'hC: begin
        dec.rd        = f_rd;
        dec.rs1       = f_rs1;
        dec.is_imm    = 1'b1;
        dec.imm       = DATA_W'(f_imm);
        dec.writes_rd = 1'b1;
      end
      default: begin
        dec.rd        = f_rd;
        dec.rs1       = f_rs1;
        dec.is_imm    = 1'b1;
        dec.imm       = DATA_W'(f_imm_s);
        dec.writes_rd = opcode inside {4'h0, 4'h2, 4'h3, 4'h8, 4'hE};
      end
    endcase
  end

`ifdef DECODE_HAZARD_EN
  localparam int unsigned NREG = 1 << REG_ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic            src_busy;

  // Sources of the incoming word checked against the current bitmap, no bypass
  always_comb begin
    src_busy = 1'b0;
    if (!(opcode inside {4'h9, 4'hD}))
      src_busy = src_busy | busy_q[f_rs1];
    if (opcode inside {4'h1, 4'h4, 4'h7})
      src_busy = src_busy | busy_q[f_rs2];
    if (opcode inside {4'h5, 4'h6, 4'hA, 4'hF})
      src_busy = src_busy | busy_q[f_rd];
    stall = in_valid && src_busy;
  end

  // Set on issue wins over a same-register write-back
  always_comb begin
    busy_d = busy_q;
    if (wb_valid)
      busy_d[wb_addr] = 1'b0;
    if (accept && dec.writes_rd)
      busy_d[f_rd] = 1'b1;
    if (flush)
      busy_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
`else
  logic unused_wb;
  assign unused_wb = wb_valid ^ (^wb_addr);
  assign stall     = 1'b0;
`endif

  assign in_ready = !rst && (!out_valid_q || out_ready) && (state_q == RUN) && !flush && !stall;
  assign accept   = in_valid && in_ready;

  // Output register and halt FSM next state
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    fields_d    = fields_q;
    if (accept) begin
      fields_d    = dec;
      out_valid_d = 1'b1;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      RUN:     if (accept && opcode == OP_HLT) state_d = HALTED;
      HALTED:  if (resume) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      fields_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      fields_q    <= fields_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = fields_q.opcode;
  assign out_rd        = fields_q.rd;
  assign out_rs1       = fields_q.rs1;
  assign out_rs2       = fields_q.rs2;
  assign out_is_imm    = fields_q.is_imm;
  assign out_imm       = fields_q.imm;
  assign out_jtarget   = fields_q.jtarget;
  assign out_writes_rd = fields_q.writes_rd;
  assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, directed handshake/halt/flush/hazard
// sequences, then random traffic against a behavioural model.
module tb_decode_stage;

`ifdef DECODE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd, out_rs1, out_rs2;
  logic        out_is_imm;
  logic [7:0]  out_imm;
  logic [11:0] out_jtarget;
  logic        out_writes_rd;
  logic        halted;
  logic        resume = 1'b0;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_addr = '0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_is_imm(out_is_imm), .out_imm(out_imm),
    .out_jtarget(out_jtarget), .out_writes_rd(out_writes_rd), .halted(halted),
    .resume(resume), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic        is_imm;
    logic [7:0]  imm;
    logic [11:0] jt;
    logic        wr;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    exp_t        exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit   m_valid, m_halted;
  exp_t m_f;
  bit   m_busy [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_fields(input string tag, input exp_t e);
    check({tag, ".opcode"}, 32'(out_opcode), 32'(e.op));
    check({tag, ".rd"}, 32'(out_rd), 32'(e.rd));
    check({tag, ".rs1"}, 32'(out_rs1), 32'(e.rs1));
    check({tag, ".rs2"}, 32'(out_rs2), 32'(e.rs2));
    check({tag, ".is_imm"}, 32'(out_is_imm), 32'(e.is_imm));
    check({tag, ".imm"}, 32'(out_imm), 32'(e.imm));
    check({tag, ".jtarget"}, 32'(out_jtarget), 32'(e.jt));
    check({tag, ".writes_rd"}, 32'(out_writes_rd), 32'(e.wr));
  endtask

  function automatic vec_t mk(input logic [15:0] w, input logic [3:0] op, input logic [2:0] rd,
                              input logic [2:0] rs1, input logic [2:0] rs2, input logic is_imm,
                              input logic [7:0] imm, input logic wr);
    vec_t v;
    v.instr = w;
    v.exp   = '{op: op, rd: rd, rs1: rs1, rs2: rs2, is_imm: is_imm, imm: imm, jt: w[11:0], wr: wr};
    return v;
  endfunction

  // Reference decode from the opcode class rules
  function automatic exp_t model_decode(input logic [15:0] w);
    exp_t e;
    logic [3:0] op;
    op     = w[15:12];
    e      = '0;
    e.op   = op;
    e.jt   = w[11:0];
    e.wr   = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hB, 4'hC, 4'hE};
    if (op inside {4'h1, 4'h4, 4'h7}) begin
      e.rd  = w[11:9];
      e.rs1 = w[8:6];
      e.rs2 = w[5:3];
    end else if (!(op inside {4'h9, 4'hD})) begin
      e.rd     = w[11:9];
      e.rs1    = w[8:6];
      e.is_imm = 1'b1;
      if (op inside {4'hB, 4'hC}) e.imm = {2'b00, w[5:0]};
      else                        e.imm = {{2{w[5]}}, w[5:0]};
    end
    return e;
  endfunction

  function automatic bit model_src_busy(input logic [15:0] w);
    logic [3:0] op;
    bit b;
    op = w[15:12];
    b  = 1'b0;
    if (!(op inside {4'h9, 4'hD}))              b |= m_busy[w[8:6]];
    if (op inside {4'h1, 4'h4, 4'h7})           b |= m_busy[w[5:3]];
    if (op inside {4'h5, 4'h6, 4'hA, 4'hF})     b |= m_busy[w[11:9]];
    return b;
  endfunction

  function automatic bit model_ready();
    bit stall;
    stall = HAZ && in_valid && model_src_busy(in_instr);
    return (!m_valid || out_ready) && !m_halted && !flush && !stall;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    bit   acc;
    exp_t d;
    acc = in_valid && model_ready();
    d   = model_decode(in_instr);
    if (HAZ) begin
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (acc && d.wr) m_busy[d.rd] = 1'b1;
      if (flush) foreach (m_busy[i]) m_busy[i] = 1'b0;
    end
    if (m_halted && resume) m_halted = 1'b0;
    else if (!m_halted && acc && d.op == 4'hD) m_halted = 1'b1;
    if (acc) begin
      m_f     = d;
      m_valid = 1'b1;
    end else if (flush || out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".halted"}, 32'(halted), 32'd0);
    check_fields(tag, '0);
  endtask

  vec_t vt [11];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(16'h0A45, 4'h0, 3'd5, 3'd1, 3'd0, 1'b1, 8'h05, 1'b1);
    vt[1]  = mk(16'h0A7E, 4'h0, 3'd5, 3'd1, 3'd0, 1'b1, 8'hFE, 1'b1);
    vt[2]  = mk(16'hC27E, 4'hC, 3'd1, 3'd1, 3'd0, 1'b1, 8'h3E, 1'b1);
    vt[3]  = mk(16'h1298, 4'h1, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1);
    vt[4]  = mk(16'h9ABC, 4'h9, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0);
    vt[5]  = mk(16'h5FE0, 4'h5, 3'd7, 3'd7, 3'd0, 1'b1, 8'hE0, 1'b0);
    vt[6]  = mk(16'hB21F, 4'hB, 3'd1, 3'd0, 3'd0, 1'b1, 8'h1F, 1'b1);
    vt[7]  = mk(16'hE6A5, 4'hE, 3'd3, 3'd2, 3'd0, 1'b1, 8'hE5, 1'b1);
    vt[8]  = mk(16'h4C70, 4'h4, 3'd6, 3'd1, 3'd6, 1'b0, 8'h00, 1'b1);
    vt[9]  = mk(16'h2B7F, 4'h2, 3'd5, 3'd5, 3'd0, 1'b1, 8'hFF, 1'b1);
    vt[10] = mk(16'hA1C0, 4'hA, 3'd0, 3'd7, 3'd0, 1'b1, 8'h00, 1'b0);

    // Reset state
    #2;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_reset.in_ready", 32'(in_ready), 32'd1);

    // Decode table, bitmap cleared by a flush before each word
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b1; in_instr = vt[i].instr;
      #1 check($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'd1);
      check_fields($sformatf("tbl%0d", i), vt[i].exp);
    end

    // Back-pressure: fields held, in_ready low, release accepts same cycle
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; in_instr = 16'h1298; out_ready = 1'b0;
    @(negedge clk);
    in_instr = 16'hE6A5;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check_fields("bp.held", vt[3].exp);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp.release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.next_valid", 32'(out_valid), 32'd1);
    check_fields("bp.next", vt[7].exp);

    // Halt and resume
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; in_instr = 16'hD000;
    @(negedge clk);
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.out_valid", 32'(out_valid), 32'd1);
    check("halt.opcode", 32'(out_opcode), 32'hD);
    check("halt.rd", 32'(out_rd), 32'd0);
    in_instr = 16'h0A45;
    #1 check("halt.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("halt.still", 32'(halted), 32'd1);
    check("halt.drained", 32'(out_valid), 32'd0);
    resume = 1'b1;
    #1 check("resume.same_cycle", 32'(in_ready), 32'd0);
    @(negedge clk);
    resume = 1'b0;
    check("resume.halted", 32'(halted), 32'd0);
    #1 check("resume.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("resume.out_valid", 32'(out_valid), 32'd1);
    check_fields("resume", vt[0].exp);

    // Flush while holding a word
    in_valid = 1'b1; in_instr = 16'h1298; out_ready = 1'b0;
    @(negedge clk);
    check("flush.pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_instr = 16'hE6A5;
    #1 check("flush.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", 32'(out_valid), 32'd0);

    // Reset mid-stream while halted with a word held
    in_valid = 1'b1; in_instr = 16'hD123;
    @(negedge clk);
    check("rst_mid.halted_before", 32'(halted), 32'd1);
    check("rst_mid.valid_before", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 check("rst_mid.ready_after", 32'(in_ready), 32'd1);

    // RAW hazard: add r1,r2,r3 then add r2,r1,r1
    @(negedge clk);
    in_valid = 1'b1; in_instr = 16'h1298;
    @(negedge clk);
    in_instr = 16'h1448;
    #1 check("haz.first", 32'(in_ready), HAZ ? 32'd0 : 32'd1);
`ifdef DECODE_HAZARD_EN
    @(negedge clk);
    #1 check("haz.stalled", 32'(in_ready), 32'd0);
    wb_valid = 1'b1; wb_addr = 3'd1;
    #1 check("haz.no_bypass", 32'(in_ready), 32'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    #1 check("haz.released", 32'(in_ready), 32'd1);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    check("haz.out_valid", 32'(out_valid), 32'd1);
    check_fields("haz.second", model_decode(16'h1448));

    // Random traffic against the model
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_halted = 1'b0; m_f = '0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("rnd.out_valid", 32'(out_valid), 32'(m_valid));
      check("rnd.halted", 32'(halted), 32'(m_halted));
      if (m_valid) check_fields("rnd", m_f);
      in_valid  = ($urandom_range(3) != 0);
      in_instr  = 16'($urandom);
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(15) == 0);
      resume    = ($urandom_range(3) == 0);
      wb_valid  = $urandom_range(1) == 1;
      wb_addr   = 3'($urandom);
      #1 check("rnd.in_ready", 32'(in_ready), 32'(model_ready()));
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
